key_debounce_ctrl: RTL and testbench
====================================

Name: key_debounce_ctrl

Overview:
Conditions a raw mechanical push-button into the clean, glitch-free en_key level consumed by the 3-second hold timer (count_3sec_ctrl). It synchronises the asynchronous pin, debounces both edges with a cycle counter and a 4-state FSM, and emits one-cycle press/release strobes. Sits between the board key pin and the hold-timer / mode logic, clocked by the 50 MHz FPGA_CLK.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples required per edge (20 ms at 50 MHz); legal range >= 2.
KEY_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
FPGA_CLK  input  1  system clock, 50 MHz, all logic on rising edge
rst  input  1  synchronous active-high reset
key_pin  input  1  raw, asynchronous button pin
en_key  output  1  debounced level; 1 = button held
f_press  output  1  one-cycle strobe on debounced press
f_release  output  1  one-cycle strobe on debounced release

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, cnt=0, both sync flops = released level, en_key=0, f_press=0, f_release=0. Reset dominates all other inputs, including mid-count and while in HELD (en_key drops on that edge, no f_release generated).
- Polarity: key_raw = key_pin XOR KEY_ACTIVE_LOW, giving 1 = pressed; applied before the synchroniser.
- Synchroniser: 2 flops, s1 <= key_raw, s2 <= s1. Only s2 feeds the FSM.
- FSM states and transitions:
  - IDLE (en_key=0): s2=1 -> PRESS_WAIT, cnt<=1. Otherwise stay, cnt<=0.
  - PRESS_WAIT (en_key=0): s2=0 -> IDLE, cnt<=0 (bounce restarts qualification). s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, en_key<=1, f_press<=1, cnt<=0. Otherwise cnt<=cnt+1.
  - HELD (en_key=1): s2=0 -> RELEASE_WAIT, cnt<=1. Otherwise stay.
  - RELEASE_WAIT (en_key=1): s2=1 -> HELD, cnt<=0. s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, en_key<=0, f_release<=1, cnt<=0. Otherwise cnt<=cnt+1.
- Strobes: f_press and f_release are registered and high for exactly one cycle; they default to 0 on every edge unless set above. They are never high in the same cycle.
- Latency: if key_raw is stable pressed before edge k, s2=1 after edge k+1 and en_key=1 (with f_press) after edge k+1+DEBOUNCE_CYCLES. Release is symmetric.
- A bounce of any length < DEBOUNCE_CYCLES s2-samples produces no output change. The counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- en_key changes only on debounced edges. Downstream count_3sec_ctrl clears on en_key=0 and therefore needs no further filtering.

Decomposition:
- Shared package key_pkg: state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3) and DEBOUNCE_20MS_50MHZ=1_000_000, which is reused by the top level alongside the 3-second constant 150_000_000.
- One sub-module: sync_2ff (1-bit two-flop synchroniser, synchronous reset to parameterised value), instantiated once here and reusable for other board inputs.

Test Plan (DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1):
- Reset: hold rst=1 for 3 cycles with key_pin toggling -> en_key=0, f_press=0, f_release=0 throughout and on the first edge after release.
- Clean press: key_pin 1->0 before edge 10 and held -> en_key=1 and f_press=1 after edge 15; f_press=0 after edge 16; en_key remains 1.
- Bounce: key_pin low for 3 cycles, high for 1, then low and held -> no f_press during the glitch; en_key rises exactly 5 edges after the final low sample is launched, and only one f_press occurs.
- Clean release: from HELD, key_pin 0->1 before edge 40 -> en_key=0 and f_release=1 after edge 45; a 2-cycle low glitch at edge 42 restarts the count and delays release accordingly.
- Reset mid-operation: assert rst while in RELEASE_WAIT with cnt=2 -> on that edge en_key=0, cnt=0, f_release never asserted; a pressed key after rst deasserts requires the full 2+4 cycles again.
- Polarity: KEY_ACTIVE_LOW=0, pin 0->1 held -> en_key=1 after the same 1+DEBOUNCE_CYCLES edges.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the board key conditioning and hold-timer logic.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // 20 ms of qualification at the 50 MHz FPGA_CLK
  localparam int unsigned DEBOUNCE_20MS_50MHZ = 1_000_000;
  // 3 s hold interval at the 50 MHz FPGA_CLK, used by count_3sec_ctrl
  localparam int unsigned HOLD_3SEC_50MHZ     = 150_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic FPGA_CLK,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Shift the raw input through two flops; reset parks both at RESET_VAL
  always_ff @(posedge FPGA_CLK) begin
    if (rst) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_debounce_ctrl.sv
// Push-button conditioner: polarity fix, 2-flop sync, edge debounce, strobes.
module key_debounce_ctrl
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned CNT_W           = 20
) (
  input  logic FPGA_CLK,
  input  logic rst,
  input  logic key_pin,
  output logic en_key,
  output logic f_press,
  output logic f_release
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_raw;
  logic             key_s2;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_done;
  logic             en_d, press_d, release_d;

  // 1 = pressed regardless of board wiring
  assign key_raw  = key_pin ^ KEY_ACTIVE_LOW;
  assign cnt_done = (cnt_q == CNT_LAST);

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .FPGA_CLK(FPGA_CLK),
    .rst     (rst),
    .d       (key_raw),
    .q       (key_s2)
  );

  // State, counter and registered outputs
  always_ff @(posedge FPGA_CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      en_key    <= 1'b0;
      f_press   <= 1'b0;
      f_release <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_key    <= en_d;
      f_press   <= press_d;
      f_release <= release_d;
    end
  end

  // Next state and qualification counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (key_s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!key_s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (key_s2) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values to be registered: level follows the wait/held state, strobes on qualifying edges
  always_comb begin
    en_d      = en_key;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE:         en_d = 1'b0;
      PRESS_WAIT: begin
        en_d = 1'b0;
        if (key_s2 && cnt_done) begin
          en_d    = 1'b1;
          press_d = 1'b1;
        end
      end
      HELD:         en_d = 1'b1;
      RELEASE_WAIT: begin
        en_d = 1'b1;
        if (!key_s2 && cnt_done) begin
          en_d      = 1'b0;
          release_d = 1'b1;
        end
      end
      default:      en_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Self-checking bench for key_debounce_ctrl with both pin polarities.
module tb_key_debounce_ctrl;

  localparam int unsigned N = 4;

  logic FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  logic rst;
  logic key_pin;
  logic key_pin_hi;
  logic en_lo, press_lo, rel_lo;
  logic en_hi, press_hi, rel_hi;

  // The active-high instance sees the same button action on an inverted pin
  assign key_pin_hi = ~key_pin;

  key_debounce_ctrl #(
    .DEBOUNCE_CYCLES(N),
    .KEY_ACTIVE_LOW (1'b1),
    .CNT_W          (3)
  ) dut_lo (
    .FPGA_CLK (FPGA_CLK),
    .rst      (rst),
    .key_pin  (key_pin),
    .en_key   (en_lo),
    .f_press  (press_lo),
    .f_release(rel_lo)
  );

  key_debounce_ctrl #(
    .DEBOUNCE_CYCLES(N),
    .KEY_ACTIVE_LOW (1'b0),
    .CNT_W          (3)
  ) dut_hi (
    .FPGA_CLK (FPGA_CLK),
    .rst      (rst),
    .key_pin  (key_pin_hi),
    .en_key   (en_hi),
    .f_press  (press_hi),
    .f_release(rel_hi)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: pressed samples reach the debouncer two edges late; the level
  // flips once N consecutive delayed samples disagree with it.
  logic m_q1 = 1'b0, m_q2 = 1'b0;
  logic m_en = 1'b0, m_press = 1'b0, m_rel = 1'b0;
  int   m_run = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic pressed, input logic r);
    logic samp;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (r) begin
      m_q1  = 1'b0;
      m_q2  = 1'b0;
      m_run = 0;
      m_en  = 1'b0;
    end else begin
      samp = m_q2;
      m_q2 = m_q1;
      m_q1 = pressed;
      if (samp != m_en) begin
        m_run++;
        if (m_run == N) begin
          m_en    = samp;
          m_run   = 0;
          m_press = samp;
          m_rel   = ~samp;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Drive one clock with the button state and reset, then check both instances
  task automatic step(input logic pressed, input logic r);
    key_pin = ~pressed;
    rst     = r;
    @(posedge FPGA_CLK);
    model_edge(pressed, r);
    #1;
    chk("en_lo",      en_lo,    m_en);
    chk("press_lo",   press_lo, m_press);
    chk("release_lo", rel_lo,   m_rel);
    chk("en_hi",      en_hi,    m_en);
    chk("press_hi",   press_hi, m_press);
    chk("release_hi", rel_hi,   m_rel);
    chk("strobe_excl", press_lo & rel_lo, 1'b0);
  endtask

  // Hold the button at lvl and count edges until en_key follows
  task automatic measure(input string tag, input logic lvl);
    int k = 0;
    do begin
      step(lvl, 1'b0);
      k++;
    end while (en_lo !== lvl && k < 20);
    chk_int(tag, k, N + 2);
  endtask

  initial begin
    key_pin = 1'b1;
    rst     = 1'b1;

    // Reset with the pin toggling, then first edge out of reset
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0);

    // Clean press, strobe drops on the following edge, level holds
    measure("press_latency", 1'b1);
    repeat (3) step(1'b1, 1'b0);

    // Clean release back to idle
    measure("release_latency", 1'b0);
    repeat (4) step(1'b0, 1'b0);

    // Press with a one-sample bounce before settling
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    measure("bounce_press_latency", 1'b1);
    repeat (2) step(1'b1, 1'b0);

    // Release with a two-sample glitch back to pressed
    repeat (2) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    measure("glitch_release_latency", 1'b0);
    repeat (4) step(1'b0, 1'b0);

    // Reset while releasing with two samples counted
    measure("press_before_reset", 1'b1);
    repeat (4) step(1'b0, 1'b0);
    chk("in_release_wait", en_lo, 1'b1);
    step(1'b0, 1'b1);
    chk("reset_drops_en", en_lo, 1'b0);
    measure("press_after_reset", 1'b1);
    repeat (2) step(1'b1, 1'b0);

    // Random bursts of bouncing and stable holds, occasional reset
    for (int seg = 0; seg < 300; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(N, N + 6))
                                        : int'($urandom_range(1, N));
      for (int i = 0; i < len; i++) begin
        step(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
